// File: rtl/lfsr_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_pattern_gen
//  Description : Parametrised LFSR pattern generator for the LED/indicator
//                path. A clock-enable tick divider paces the sequence while
//                run=1. Single-step and seed-load controls are provided.
//                Sequence wrap is flagged. The all-zero lock-up state is
//                recovered by reloading SEED.
//  Build option: define LFSR_GALOIS_EN to select the Galois feedback form.
//                When it is not defined, only the Fibonacci form is built.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_pattern_gen #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] TAPS    = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0] SEED    = {WIDTH{1'b1}},
  parameter int               CLK_HZ  = 12000000,
  parameter int               TICK_HZ = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] pattern,
  output logic             tick,
  output logic             wrap,
  output logic             lockup_fix
);

  // --------------------------------------------------------------------------
  // Divider sizing
  // --------------------------------------------------------------------------
  localparam int DIV   = CLK_HZ / TICK_HZ;
  // Keep at least one counter bit so an illegal DIV still elaborates far
  // enough to hit the parameter checks below.
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  generate
    if (DIV < 2) begin : g_bad_div
      $error("lfsr_pattern_gen: CLK_HZ/TICK_HZ must be at least 2");
    end
    if ((WIDTH < 3) || (WIDTH > 32)) begin : g_bad_width
      $error("lfsr_pattern_gen: WIDTH must be within 3..32");
    end
    if (SEED == '0) begin : g_bad_seed
      $error("lfsr_pattern_gen: SEED must be non-zero");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Internal state
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt;         // tick divider count
  logic [WIDTH-1:0] state;       // live LFSR register
  logic [WIDTH-1:0] start;       // value whose recurrence marks a wrap
  logic [WIDTH-1:0] next_state;  // one LFSR advance from the current state
  logic             adv;         // advance request this cycle
  logic             state_zero;  // lock-up detected
  logic             seed_zero;   // load requested with an unusable seed

  // tick comes straight from the counter register and run, so it carries no
  // path from step/load/seed_in.
  assign tick       = run && (cnt == CNT_MAX);
  // A step that lands on a tick cycle still produces exactly one advance.
  assign adv        = tick | step;
  assign state_zero = (state == '0);
  assign seed_zero  = (seed_in == '0);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
`ifdef LFSR_GALOIS_EN
  // Galois form: the tap mask is rotated left by one so that the same TAPS
  // value gives the same period as the Fibonacci form for primitive taps.
  localparam logic [WIDTH-1:0] TAPS_G = {TAPS[WIDTH-2:0], TAPS[WIDTH-1]};

  logic galois_fb;

  assign galois_fb  = state[WIDTH-1];
  assign next_state = {state[WIDTH-2:0], 1'b0} ^ (galois_fb ? TAPS_G : '0);
`else
  // Fibonacci form: XOR of the tapped bits is shifted in at the LSB.
  logic fib_fb;

  assign fib_fb     = ^(state & TAPS);
  assign next_state = {state[WIDTH-2:0], fib_fb};
`endif

  // --------------------------------------------------------------------------
  // Tick divider: free-runs 0..DIV-1 while run=1, holds otherwise, and is
  // realigned by a seed load so the next tick is a full period away.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (run) begin
      if (cnt == CNT_MAX) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // LFSR state, wrap reference and status pulses.
  // Order of precedence: load, then zero recovery, then advance, else hold.
  // A load overrides a zero state because it replaces the state anyway.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SEED;
      start      <= SEED;
      wrap       <= 1'b0;
      lockup_fix <= 1'b0;
    end else begin
      wrap       <= 1'b0;
      lockup_fix <= 1'b0;
      if (load) begin
        if (seed_zero) begin
          state      <= SEED;
          start      <= SEED;
          lockup_fix <= 1'b1;
        end else begin
          state <= seed_in;
          start <= seed_in;
        end
      end else if (state_zero) begin
        state      <= SEED;
        start      <= SEED;
        lockup_fix <= 1'b1;
      end else if (adv) begin
        state <= next_state;
        wrap  <= (next_state == start);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output stage: re-register the state so the LED bank sees a clean,
  // glitch-free copy one cycle behind the LFSR.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern <= SEED;
    end else begin
      pattern <= state;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lfsr_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_pattern_gen
//  Description : Self-checking bench for lfsr_pattern_gen, WIDTH=4 setup.
//                Define LFSR_GALOIS_EN to exercise the Galois build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_pattern_gen;

  localparam int WIDTH   = 4;
  localparam int TAPS_I  = 4'b1100;
  localparam int SEED_I  = 4'hF;
  localparam int CLK_HZ  = 8;
  localparam int TICK_HZ = 2;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int MASK    = (1 << WIDTH) - 1;

  logic             clk;
  logic             rst;
  logic             run;
  logic             step;
  logic             load;
  logic [WIDTH-1:0] seed_in;
  logic [WIDTH-1:0] pattern;
  logic             tick;
  logic             wrap;
  logic             lockup_fix;

  int n_tests;
  int n_fail;

  // Behavioural reference
  int   m_cnt;
  int   m_state;
  int   m_start;
  int   m_pattern;
  logic m_wrap;
  logic m_fix;
  logic last_tick;

  int seq_exp [16];

  lfsr_pattern_gen #(
    .WIDTH   (WIDTH),
    .TAPS    (4'b1100),
    .SEED    (4'hF),
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .step       (step),
    .load       (load),
    .seed_in    (seed_in),
    .pattern    (pattern),
    .tick       (tick),
    .wrap       (wrap),
    .lockup_fix (lockup_fix)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One LFSR advance, from the arithmetic definition of each form.
  function automatic int model_next(input int s);
    int r;
`ifdef LFSR_GALOIS_EN
    int tg;
    tg = ((TAPS_I << 1) | (TAPS_I >> (WIDTH - 1))) & MASK;
    r  = (s << 1) & MASK;
    if (((s >> (WIDTH - 1)) & 1) == 1) r = r ^ tg;
`else
    int fb;
    fb = $countones(s & TAPS_I) % 2;
    r  = ((s << 1) & MASK) | fb;
`endif
    return r;
  endfunction

  task automatic model_reset();
    m_cnt     = 0;
    m_state   = SEED_I;
    m_start   = SEED_I;
    m_pattern = SEED_I;
    m_wrap    = 1'b0;
    m_fix     = 1'b0;
  endtask

  task automatic model_clock(input logic r, input logic s, input logic l, input int sd);
    logic t;
    int   nxt;
    t         = r && (m_cnt == DIV - 1);
    m_pattern = m_state;
    m_wrap    = 1'b0;
    m_fix     = 1'b0;
    if (l) begin
      m_cnt = 0;
      if (sd == 0) begin
        m_state = SEED_I;
        m_start = SEED_I;
        m_fix   = 1'b1;
      end else begin
        m_state = sd;
        m_start = sd;
      end
    end else begin
      if (r) m_cnt = (m_cnt + 1) % DIV;
      if (m_state == 0) begin
        m_state = SEED_I;
        m_start = SEED_I;
        m_fix   = 1'b1;
      end else if (t || s) begin
        nxt     = model_next(m_state);
        m_wrap  = (nxt == m_start);
        m_state = nxt;
      end
    end
  endtask

  // Apply inputs for one clock, check tick before the edge and the
  // registered outputs just after it.
  task automatic do_cycle(input logic r, input logic s, input logic l, input logic [WIDTH-1:0] sd);
    logic exp_tick;
    run     = r;
    step    = s;
    load    = l;
    seed_in = sd;
    #1;
    exp_tick = r && (m_cnt == DIV - 1);
    check("tick", tick, exp_tick);
    last_tick = tick;
    @(posedge clk);
    model_clock(r, s, l, int'(sd));
    #1;
    check("pattern", pattern, m_pattern);
    check("wrap", wrap, m_wrap);
    check("lockup_fix", lockup_fix, m_fix);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int idx;
    int wraps;
    int ticks;
    int prev;
    int n;
    logic found;

`ifdef LFSR_GALOIS_EN
    seq_exp = '{4'hF, 4'h7, 4'hE, 4'h5, 4'hA, 4'hD, 4'h3, 4'h6,
                4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h9, 4'hB, 4'hF};
`else
    seq_exp = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9,
                4'h3, 4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7, 4'hF};
`endif
    n_tests   = 0;
    n_fail    = 0;
    last_tick = 1'b0;
    rst       = 1'b1;
    run       = 1'b0;
    step      = 1'b0;
    load      = 1'b0;
    seed_in   = '0;
    model_reset();

    // Reset state
    #3;
    check("rst_pattern", pattern, SEED_I);
    check("rst_tick", tick, 0);
    check("rst_wrap", wrap, 0);
    check("rst_fix", lockup_fix, 0);
    @(negedge clk);
    rst = 1'b0;

    // Three single steps with run=0
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b0, 1'b1, 1'b0, '0);
      do_cycle(1'b0, 1'b0, 1'b0, '0);
    end
    do_cycle(1'b0, 1'b0, 1'b0, '0);
    check("step_seq", pattern, seq_exp[3]);

    // Reload F and run 64 cycles: 16 ticks, one wrap, sequence order
    do_cycle(1'b0, 1'b0, 1'b1, 4'hF);
    do_cycle(1'b0, 1'b0, 1'b0, '0);
    wraps = 0;
    ticks = 0;
    idx   = 0;
    prev  = int'(pattern);
    for (int i = 0; i < 64; i++) begin
      do_cycle(1'b1, 1'b0, 1'b0, '0);
      if (last_tick) ticks++;
      if (wrap) wraps++;
      if (int'(pattern) != prev) begin
        idx++;
        check("run_seq", pattern, seq_exp[idx % 15]);
        check("nonzero", (pattern != 0), 1);
        prev = int'(pattern);
      end
    end
    check("run_ticks", ticks, 16);
    check("run_wraps", wraps, 1);

    // Load coincident with tick: load wins, counter realigns
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (m_cnt == DIV - 1) found = 1'b1;
      else do_cycle(1'b1, 1'b0, 1'b0, '0);
    end
    check("tick_align", found, 1);
    do_cycle(1'b1, 1'b0, 1'b1, 4'h3);
    check("load_tick_seen", last_tick, 1);
    do_cycle(1'b1, 1'b0, 1'b0, '0);
    check("load_wins", pattern, 4'h3);
    ticks = 0;
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      do_cycle(1'b1, 1'b0, 1'b0, '0);
      if (last_tick) ticks++;
      if (wrap) found = 1'b1;
    end
    check("wrap_after_load", found, 1);
    check("advances_to_wrap", ticks, 15);

    // Zero seed load falls back to SEED with a lockup_fix pulse
    do_cycle(1'b0, 1'b0, 1'b1, 4'h0);
    check("zero_load_fix", lockup_fix, 1);
    do_cycle(1'b0, 1'b1, 1'b0, '0);
    check("zero_load_fix_end", lockup_fix, 0);
    check("zero_load_pat", pattern, SEED_I);
    do_cycle(1'b0, 1'b0, 1'b0, '0);
    check("zero_load_next", pattern, seq_exp[1]);

    // Asynchronous reset mid-run while pattern shows 9
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      do_cycle(1'b1, 1'b0, 1'b0, '0);
      if (pattern == 4'h9) found = 1'b1;
    end
    check("reach_9", found, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_pattern", pattern, SEED_I);
    check("async_rst_tick", tick, 0);
    model_reset();
    @(negedge clk);
    rst   = 1'b0;
    n     = 0;
    found = 1'b0;
    for (int i = 1; i <= 10 && !found; i++) begin
      do_cycle(1'b1, 1'b0, 1'b0, '0);
      if (last_tick) begin
        found = 1'b1;
        n     = i;
      end
    end
    check("tick_after_rst", n, DIV);

    // Randomised traffic against the reference
    for (int i = 0; i < 500; i++) begin
      do_cycle(($urandom % 4) != 0, ($urandom % 5) == 0, ($urandom % 16) == 0,
               WIDTH'($urandom % 16));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lfsr_pattern_gen.md
Name: lfsr_pattern_gen

Overview:
Parametrised LFSR pattern generator for the LED/indicator path. It uses a clock-enable tick divider rather than a derived clock, supports any width and tap set, and accepts run, single-step and seed-load controls. It detects sequence wrap and guards against the all-zero lock-up state. Its output drives the LED register bank directly.

Parameters:
WIDTH, 8, LFSR and pattern width in bits; legal range 3..32.
TAPS, 8'hB8, feedback tap mask, WIDTH bits; bit i set means state[i] feeds the XOR.
SEED, all ones, reset and fallback state, WIDTH bits; must be non-zero.
CLK_HZ, 12000000, input clock frequency.
TICK_HZ, 2, advance rate while running.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
run  in  1  level; 1 = advance once per tick
step  in  1  one-cycle advance request; honoured regardless of run
load  in  1  one-cycle seed-load request
seed_in  in  WIDTH  seed value sampled when load=1
pattern  out  WIDTH  registered LFSR state for the LEDs
tick  out  1  one-cycle pulse at each divider terminal count while run=1
wrap  out  1  one-cycle pulse when the state returns to the sequence start value
lockup_fix  out  1  one-cycle pulse when a zero state was replaced by SEED

Behaviour:
- DIV = CLK_HZ/TICK_HZ (integer; elaboration error if < 2). Counter width is $clog2(DIV).
- Divider: cnt counts 0..DIV-1 and wraps to 0.
  - Counts only while run=1; holds its value while run=0.
  - tick=1 in the cycle when cnt==DIV-1 and run=1.
- adv = tick | step; a single step coincident with tick gives exactly one advance.
- Next state, Fibonacci form:
  - fb = XOR-reduce(state & TAPS).
  - next = {state[WIDTH-2:0], fb}.
- Priority per cycle: load > adv > hold.
  - load: state <= seed_in and start <= seed_in. If seed_in==0, both take SEED and lockup_fix pulses.
  - load resets cnt to 0.
  - adv: state <= next.
- Zero guard: if state is ever 0 (e.g. bad taps or SEU), the next cycle forces state <= SEED and start <= SEED, and lockup_fix pulses.
- wrap: registered. It asserts in the cycle after an adv whose next==start. It never asserts on load.
- Latency:
  - state updates on the clock edge that samples tick or step.
  - pattern <= state one cycle later, so pattern changes 2 cycles after the tick/step cycle.
- Reset values: cnt=0, state=SEED, start=SEED, pattern=SEED, tick=0, wrap=0, lockup_fix=0.
- Reset mid-count: cnt and state return to reset values immediately, with no partial advance. The first tick after release comes DIV cycles later, given run=1.
- Outputs are glitch-free registers; no output is combinational from inputs except tick (from the cnt register and run).

Optional Feature:
LFSR_GALOIS_EN:
- Defined: Galois form.
  - fb = state[WIDTH-1].
  - next = ({state[WIDTH-2:0],1'b0}) ^ (fb ? TAPS_G : 0), where TAPS_G is TAPS rotated left by 1.
  - Zero guard, wrap and latency are unchanged. The period is equal for primitive taps but the sequence order differs.
- Undefined: Fibonacci form only, with no Galois logic.

Test Plan:
- WIDTH=4, TAPS=4'b1100, SEED=4'hF, CLK_HZ=8, TICK_HZ=2 (DIV=4), run=1:
  - tick pulses every 4 cycles.
  - pattern sequence F,E,C,8,1,2,4,9,3,6,D,A,5,B,7,F.
  - wrap pulses once per 15 ticks.
- run=0 with three step pulses from reset: pattern F→E→C→8; tick stays 0; cnt is held at 0.
- load=1 with seed_in=4'h3 in the same cycle as tick: state=3 (load wins) and cnt=0. Wrap follows 15 advances later on return to 3.
- load=1 with seed_in=0: state=F and lockup_fix=1 for one cycle; the sequence continues F,E,...
- rst asserted mid-run while pattern=9: pattern=F and tick=0 asynchronously. After release the next tick arrives exactly 4 cycles later.
- LFSR_GALOIS_EN defined, same parameters: a period of 15 from F is reached, wrap pulses, and no state equals 0.
